// File: rtl/layer2_window_fetch.sv
// rtl/layer2_window_fetch.sv - streams 3x3x8 conv windows from layer-1 memory as 5 two-tap beats
module layer2_window_fetch #(
    parameter int IN_DIM    = 14,
    parameter int K         = 3,
    parameter int ROW_PITCH = 56,
    parameter int COL_PITCH = 2,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_busy,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    input  logic [63:0]       mem_data1,
    input  logic [63:0]       mem_data2,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [63:0]       win_tap_a,
    output logic [63:0]       win_tap_b,
    output logic              win_tap_b_en,
    output logic [3:0]        win_row,
    output logic [3:0]        win_col,
    output logic [2:0]        win_beat,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    localparam int OUT_DIM = IN_DIM - K + 1;
    localparam logic [3:0] LAST_RC   = 4'(OUT_DIM - 1);
    localparam logic [2:0] LAST_BEAT = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d, col_q, col_d;
    logic [2:0]  beat_q, beat_d;
    logic        inflight_q, inflight_d;
    logic [3:0]  pend_row_q, pend_row_d, pend_col_q, pend_col_d;
    logic [2:0]  pend_beat_q, pend_beat_d;
    logic        pend_last_q, pend_last_d;

    logic [63:0] fifo_a_q [2];
    logic [63:0] fifo_a_d [2];
    logic [63:0] fifo_b_q [2];
    logic [63:0] fifo_b_d [2];
    logic        fifo_ben_q [2];
    logic        fifo_ben_d [2];
    logic [3:0]  fifo_row_q [2];
    logic [3:0]  fifo_row_d [2];
    logic [3:0]  fifo_col_q [2];
    logic [3:0]  fifo_col_d [2];
    logic [2:0]  fifo_beat_q [2];
    logic [2:0]  fifo_beat_d [2];
    logic        fifo_last_q [2];
    logic        fifo_last_d [2];
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        pop, push, last_issue, pend_ben;
    logic [2:0]  occ;
    logic [3:0]  tap_a_idx, tap_b_idx;
    logic [ADDR_W-1:0] addr_a, addr_b;

    // Pixel address of tap t in window (r,c): pixel (r+t/K, c+t%K)
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [3:0] r, input logic [3:0] c,
                                                   input logic [3:0] t);
        int pr;
        int pc;
        pr = int'(r) + int'(t) / K;
        pc = int'(c) + int'(t) % K;
        return ADDR_W'(ROW_PITCH * pr + COL_PITCH * pc);
    endfunction

    // Issue decision, tap addresses and FIFO head presentation
    always_comb begin
        win_valid    = (count_q != 2'd0);
        pop          = win_valid && win_ready;
        push         = inflight_q;
        occ          = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        mem_load     = (state_q == S_FETCH) && !mem_busy && (occ < 3'd2);
        last_issue   = (row_q == LAST_RC) && (col_q == LAST_RC) && (beat_q == LAST_BEAT);
        tap_a_idx    = {beat_q, 1'b0};
        tap_b_idx    = (beat_q == LAST_BEAT) ? tap_a_idx : tap_a_idx + 4'd1;
        addr_a       = tap_addr(row_q, col_q, tap_a_idx);
        addr_b       = tap_addr(row_q, col_q, tap_b_idx);
        mem_addr1    = mem_load ? addr_a : '0;
        mem_addr2    = mem_load ? addr_b : '0;
        pend_ben     = (pend_beat_q != LAST_BEAT);
        win_tap_a    = fifo_a_q[rd_ptr_q];
        win_tap_b    = fifo_b_q[rd_ptr_q];
        win_tap_b_en = fifo_ben_q[rd_ptr_q];
        win_row      = fifo_row_q[rd_ptr_q];
        win_col      = fifo_col_q[rd_ptr_q];
        win_beat     = fifo_beat_q[rd_ptr_q];
        win_last     = fifo_last_q[rd_ptr_q];
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
    end

    // Next-state: sweep FSM, issue counters, in-flight tag and return FIFO
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        beat_d      = beat_q;
        inflight_d  = mem_load;
        pend_row_d  = mem_load ? row_q : pend_row_q;
        pend_col_d  = mem_load ? col_q : pend_col_q;
        pend_beat_d = mem_load ? beat_q : pend_beat_q;
        pend_last_d = mem_load ? last_issue : pend_last_q;
        fifo_a_d    = fifo_a_q;
        fifo_b_d    = fifo_b_q;
        fifo_ben_d  = fifo_ben_q;
        fifo_row_d  = fifo_row_q;
        fifo_col_d  = fifo_col_q;
        fifo_beat_d = fifo_beat_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    beat_d  = '0;
                end
            end
            S_FETCH: begin
                if (mem_load) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (col_q == LAST_RC) begin
                            col_d = '0;
                            row_d = (row_q == LAST_RC) ? 4'd0 : row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                    if (last_issue) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the final beat is accepted so done follows it by one cycle
                if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Returned data always lands; the issue rule guarantees a free slot
        if (push) begin
            fifo_a_d[wr_ptr_q]    = mem_data1;
            fifo_b_d[wr_ptr_q]    = pend_ben ? mem_data2 : 64'd0;
            fifo_ben_d[wr_ptr_q]  = pend_ben;
            fifo_row_d[wr_ptr_q]  = pend_row_q;
            fifo_col_d[wr_ptr_q]  = pend_col_q;
            fifo_beat_d[wr_ptr_q] = pend_beat_q;
            fifo_last_d[wr_ptr_q] = pend_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // State registers; reset aborts any sweep and discards in-flight data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            beat_q      <= '0;
            inflight_q  <= 1'b0;
            pend_row_q  <= '0;
            pend_col_q  <= '0;
            pend_beat_q <= '0;
            pend_last_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_a_q[i]    <= '0;
                fifo_b_q[i]    <= '0;
                fifo_ben_q[i]  <= 1'b0;
                fifo_row_q[i]  <= '0;
                fifo_col_q[i]  <= '0;
                fifo_beat_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            beat_q      <= beat_d;
            inflight_q  <= inflight_d;
            pend_row_q  <= pend_row_d;
            pend_col_q  <= pend_col_d;
            pend_beat_q <= pend_beat_d;
            pend_last_q <= pend_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_a_q    <= fifo_a_d;
            fifo_b_q    <= fifo_b_d;
            fifo_ben_q  <= fifo_ben_d;
            fifo_row_q  <= fifo_row_d;
            fifo_col_q  <= fifo_col_d;
            fifo_beat_q <= fifo_beat_d;
            fifo_last_q <= fifo_last_d;
        end
    end

endmodule

// File: tb/tb_layer2_window_fetch.sv
// tb/tb_layer2_window_fetch.sv - scoreboard bench for layer2_window_fetch
module tb_layer2_window_fetch;

    logic        clk = 1'b0;
    logic        rst, start, mem_busy, mem_load, win_valid, win_ready;
    logic [9:0]  mem_addr1, mem_addr2;
    logic [63:0] mem_data1 = '0, mem_data2 = '0, win_tap_a, win_tap_b;
    logic        win_tap_b_en, win_last, busy, done;
    logic [3:0]  win_row, win_col;
    logic [2:0]  win_beat;

    layer2_window_fetch dut (
        .clk(clk), .rst(rst), .start(start), .mem_busy(mem_busy), .mem_load(mem_load),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_data1(mem_data1), .mem_data2(mem_data2),
        .win_valid(win_valid), .win_ready(win_ready), .win_tap_a(win_tap_a), .win_tap_b(win_tap_b),
        .win_tap_b_en(win_tap_b_en), .win_row(win_row), .win_col(win_col), .win_beat(win_beat),
        .win_last(win_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef logic [140:0] beat_t;

    beat_t       sb_q[$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, pops = 0, loads = 0, done_cnt = 0;
    int          first_pop_cyc = 0, last_pop_cyc = -10;
    bit          ready_mode = 0, prev_stall = 0;
    beat_t       held;
    logic [63:0] first_a, first_b, last_a;
    logic        last_ben;

    task automatic check(input string name, input beat_t act, input beat_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pix(input int r, input int c);
        logic [63:0] w;
        for (int n = 0; n < 8; n++) w[8*n +: 8] = 8'(r * 14 + c + n);
        return w;
    endfunction

    function automatic beat_t exp_beat(input int w, input int k);
        int r, c, ta, tb;
        logic [63:0] a, b;
        r  = w / 12;
        c  = w % 12;
        ta = 2 * k;
        tb = 2 * k + 1;
        a  = pix(r + ta / 3, c + ta % 3);
        b  = (k == 4) ? 64'd0 : pix(r + tb / 3, c + tb % 3);
        return {a, b, (k != 4), 4'(r), 4'(c), 3'(k), (w == 143 && k == 4)};
    endfunction

    function automatic logic [9:0] exp_addr(input int i, input bit port2);
        int w, k, r, c, t;
        w = i / 5;
        k = i % 5;
        r = w / 12;
        c = w % 12;
        t = (port2 && k != 4) ? 2 * k + 1 : 2 * k;
        return 10'(56 * (r + t / 3) + 2 * (c + t % 3));
    endfunction

    // Layer-1 memory model: one-cycle read, pixel decoded back from address
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_load) begin
            mem_data1 <= pix(int'(mem_addr1) / 56, (int'(mem_addr1) % 56) / 2);
            mem_data2 <= pix(int'(mem_addr2) / 56, (int'(mem_addr2) % 56) / 2);
        end
    end

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            win_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: addresses, stalls, stability, occupancy, beats and done timing
    always @(negedge clk) begin
        beat_t act;
        act = {win_tap_a, win_tap_b, win_tap_b_en, win_row, win_col, win_beat, win_last};
        if (!rst) begin
            if (mem_busy) check("busy_no_load", mem_load, 0);
            check("fifo_occupancy", ((loads - pops) <= 2), 1);
            if (mem_load) begin
                check("addr1", mem_addr1, exp_addr(loads, 0));
                check("addr2", mem_addr2, exp_addr(loads, 1));
                if (loads == 337) begin
                    check("addr1_w5_7_b2", mem_addr1, 352);
                    check("addr2_w5_7_b2", mem_addr2, 354);
                end
                loads++;
            end
            if (prev_stall && win_valid) check("stall_hold", act, held);
            if (win_valid && win_ready) begin
                if (sb_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("beat", act, sb_q.pop_front());
                end
                if (pops == 0) begin
                    first_pop_cyc = cyc;
                    first_a = win_tap_a;
                    first_b = win_tap_b;
                end
                if (win_last) begin
                    last_pop_cyc = cyc;
                    last_a = win_tap_a;
                    last_ben = win_tap_b_en;
                end
                pops++;
            end
            prev_stall = win_valid && !win_ready;
            held = act;
            if (done) begin
                done_cnt++;
                check("done_timing", cyc - last_pop_cyc, 1);
            end
        end
    end

    task automatic run_sweep(input bit rnd, input int busy_at, input int rst_at, input bit extra,
                             input bit chk_timing);
        int n, busy_left, lat, done_wait;
        bit busy_done, finished;
        for (int w = 0; w < 144; w++)
            for (int k = 0; k < 5; k++) sb_q.push_back(exp_beat(w, k));
        pops = 0; loads = 0; done_cnt = 0; prev_stall = 0; ready_mode = rnd;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (chk_timing) check("load_latency", mem_load, 1);
        lat = -1; n = 0; busy_left = 0; busy_done = 0; finished = 0; done_wait = 0;
        while (!finished && n < 6000) begin
            if (lat < 0 && win_valid) lat = n;
            @(posedge clk); #1;
            n++;
            start = (extra && (n == 5 || n == 400));
            if (busy_at >= 0 && !busy_done && pops >= busy_at) begin
                mem_busy = 1'b1; busy_left = 10; busy_done = 1;
            end else if (busy_left > 1) begin
                busy_left--;
            end else begin
                busy_left = 0; mem_busy = 1'b0;
            end
            if (rst_at >= 0 && pops >= rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_win_valid", win_valid, 0);
                check("rst_mem_load", mem_load, 0);
                check("rst_busy", busy, 0);
                finished = 1;
            end
            if (done_cnt > 0) begin
                done_wait++;
                if (done_wait >= 20) finished = 1;
            end
        end
        check("sweep_timeout", finished, 1);
        mem_busy = 1'b0;
        start = 1'b0;
        if (rst_at < 0) begin
            check("beat_count", pops, 720);
            check("done_count", done_cnt, 1);
            check("queue_empty", sb_q.size(), 0);
            if (chk_timing) begin
                check("win_latency", lat, 2);
                check("back_to_back", last_pop_cyc - first_pop_cyc, 719);
                check("first_tap_a", first_a, 64'h0706050403020100);
                check("first_tap_b", first_b, 64'h0807060504030201);
                check("last_tap_a", last_a, 64'hCAC9C8C7C6C5C4C3);
                check("last_tap_b_en", last_ben, 0);
            end
        end else begin
            sb_q.delete();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_load", mem_load, 0);
        check("reset_win_valid", win_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_addr1", mem_addr1, 0);
        check("reset_addr2", mem_addr2, 0);
        check("reset_tap_a", win_tap_a, 0);
        check("reset_row_col_beat", {win_row, win_col, win_beat}, 0);
        rst = 1'b0;
        run_sweep(0, -1, -1, 0, 1);
        run_sweep(1, -1, -1, 0, 0);
        run_sweep(0, 37, -1, 0, 0);
        run_sweep(0, -1, 300, 0, 0);
        run_sweep(0, -1, -1, 0, 1);
        run_sweep(0, -1, -1, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
